// File: rtl/hs_cmd_initiator.sv
// hs_cmd_initiator
//   Turns one burst request into a run of single-beat commands on a
//   valid/ready command channel. Addresses increment and wrap modulo
//   2^ADDR_WD. Write data is seed + beat index. Reads are tracked with an
//   outstanding counter capped at MAX_OUT. In-order read responses are
//   forwarded downstream, and rd_last marks the final response of the burst.
//
//   Optional build macro HS_INIT_RD_CHECK_EN: compares each accepted read
//   response i against seed + i and raises the sticky err_mismatch on a
//   difference. When the macro is undefined, err_mismatch is tied low.
//
// Ports
//   clk, rstn                  clock, asynchronous active-low reset
//   req_valid/req_ready        burst request handshake
//   req_write/addr/len/data    burst type, start address, beats-1, data seed
//   cmd_valid/cmd_ready        command beat handshake
//   cmd_write/addr/data        registered command fields
//   rsp_valid/rsp_ready/data   read response from target
//   rd_valid/rd_ready/data     read data to downstream, rd_last on final beat
//   busy                       burst in progress
//   done                       one-cycle pulse when a burst completes
//   err_unexp                  sticky: response seen with nothing outstanding
//   err_mismatch               sticky: read data differed from seed + index
module hs_cmd_initiator #(
  parameter int DATA_WD = 4,
  parameter int ADDR_WD = 4,
  parameter int LEN_WD  = 4,
  parameter int MAX_OUT = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  input  logic               req_write,
  input  logic [ADDR_WD-1:0] req_addr,
  input  logic [LEN_WD-1:0]  req_len,
  input  logic [DATA_WD-1:0] req_data,
  output logic               req_ready,
  output logic               cmd_valid,
  output logic               cmd_write,
  output logic [ADDR_WD-1:0] cmd_addr,
  output logic [DATA_WD-1:0] cmd_data,
  input  logic               cmd_ready,
  input  logic               rsp_valid,
  input  logic [DATA_WD-1:0] rsp_data,
  output logic               rsp_ready,
  output logic               rd_valid,
  output logic [DATA_WD-1:0] rd_data,
  output logic               rd_last,
  input  logic               rd_ready,
  output logic               busy,
  output logic               done,
  output logic               err_unexp,
  output logic               err_mismatch
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUT);
  localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic               wr_q;
  logic [ADDR_WD-1:0] addr_q;
  logic [DATA_WD-1:0] data_q;
  logic [LEN_WD-1:0]  len_q;
  logic [LEN_WD-1:0]  beat_q;
  logic [OUT_W-1:0]   out_q;
  logic               done_q;
  logic               err_unexp_q;
  logic               done_set;

  logic req_fire, cmd_fire, rsp_fire, rsp_acc, out_zero;

  // A response is only passed downstream while a read is outstanding.
  // Otherwise it is swallowed, so a stray response can never stall the target.
  assign out_zero  = (out_q == '0);
  assign rsp_ready = rd_ready || out_zero;
  assign rd_valid  = rsp_valid && !out_zero;
  assign rsp_fire  = rsp_valid && rsp_ready;
  assign rsp_acc   = rsp_fire && !out_zero;
  assign req_fire  = req_valid && req_ready;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    cmd_valid = 1'b0;
    done_set  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        // Reads hold off while the outstanding window is full.
        cmd_valid = wr_q || (out_q != OUT_MAX);
        if (cmd_valid && cmd_ready && (beat_q == len_q)) begin
          if (wr_q) begin
            state_nxt = IDLE;
            done_set  = 1'b1;
          end else begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (rsp_acc && (out_q == OUT_ONE)) begin
          state_nxt = IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      out_q       <= '0;
      done_q      <= 1'b0;
      err_unexp_q <= 1'b0;
    end else begin
      done_q <= done_set;
      if (req_fire) begin
        wr_q   <= req_write;
        addr_q <= req_addr;
        data_q <= req_data;
        len_q  <= req_len;
        beat_q <= '0;
      end else if (cmd_fire) begin
        addr_q <= addr_q + ADDR_WD'(1);
        data_q <= data_q + DATA_WD'(1);
        beat_q <= beat_q + LEN_WD'(1);
      end
      // A simultaneous issue and return leave the count unchanged.
      case ({cmd_fire && !wr_q, rsp_acc})
        2'b10:   out_q <= out_q + OUT_ONE;
        2'b01:   out_q <= out_q - OUT_ONE;
        default: out_q <= out_q;
      endcase
      if (rsp_fire && out_zero) err_unexp_q <= 1'b1;
    end
  end

`ifdef HS_INIT_RD_CHECK_EN
  logic [DATA_WD-1:0] seed_q;
  logic [DATA_WD-1:0] rsp_idx_q;
  logic               err_mm_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      seed_q    <= '0;
      rsp_idx_q <= '0;
      err_mm_q  <= 1'b0;
    end else if (req_fire) begin
      seed_q    <= req_data;
      rsp_idx_q <= '0;
    end else if (rsp_acc) begin
      rsp_idx_q <= rsp_idx_q + DATA_WD'(1);
      if (rsp_data != DATA_WD'(seed_q + rsp_idx_q)) err_mm_q <= 1'b1;
    end
  end

  assign err_mismatch = err_mm_q;
`else
  assign err_mismatch = 1'b0;
`endif

  assign cmd_write = wr_q;
  assign cmd_addr  = addr_q;
  assign cmd_data  = data_q;
  assign rd_data   = rsp_data;
  assign rd_last   = (state == DRAIN) && (out_q == OUT_ONE);
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign err_unexp = err_unexp_q;

endmodule

// File: tb/tb_hs_cmd_initiator.sv
// Testbench for hs_cmd_initiator.
//   Randomized handshakes are checked every cycle against a burst-level
//   reference model. The model tracks beats issued, reads outstanding,
//   responses returned and the sticky error flags using plain integers and
//   a queue. The bench acts as the responder: it returns seed + beat for
//   each read, and it can corrupt beat 0 or inject a stray response.
module tb_hs_cmd_initiator;
  localparam int DW = 4;
  localparam int AW = 4;
  localparam int LW = 4;
  localparam int MO = 4;
  localparam int AMASK = (1 << AW) - 1;
  localparam int DMASK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_write, req_ready;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_data;
  logic          cmd_valid, cmd_write, cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rd_valid, rd_last, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, done, err_unexp, err_mismatch;

  always #5 clk = ~clk;

  hs_cmd_initiator #(.DATA_WD(DW), .ADDR_WD(AW), .LEN_WD(LW), .MAX_OUT(MO)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_len(req_len), .req_data(req_data), .req_ready(req_ready),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy), .done(done), .err_unexp(err_unexp), .err_mismatch(err_mismatch)
  );

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  bit active, m_write, done_e, eu_e, em_e;
  int m_addr, m_len, m_seed, issued, m_out, resp_cnt;
  int dq[$];

  // stimulus knobs
  bit cr_rand, rr_rand, rs_rand, rsp_en, inj, corrupt0;
  bit rr_val = 1'b1;
  int obs_cmd_fires;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_write", cmd_write, 0);
    chk("rst_cmd_addr", cmd_addr, 0);
    chk("rst_cmd_data", cmd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err_unexp", err_unexp, 0);
    chk("rst_err_mismatch", err_mismatch, 0);
    chk("rst_rsp_ready", rsp_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0; req_valid = 1'b0; rsp_valid = 1'b0; inj = 1'b0;
    active = 0; done_e = 0; eu_e = 0; em_e = 0; m_out = 0; issued = 0; resp_cnt = 0;
    dq.delete();
    #1 chk_reset_vals();
    repeat (2) @(negedge clk);
    #1 chk_reset_vals();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // One clock cycle: drive after the falling edge, check, then advance the
  // model by the handshakes that complete at the next rising edge.
  task automatic cyc(input bit rq);
    bit cv_e, cfire, rfire, racc, req_f;
    @(negedge clk);
    req_valid = rq;
    cmd_ready = cr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    rd_ready  = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
    if (inj) begin
      rsp_valid = 1'b1;
      rsp_data  = 4'h9;
    end else begin
      rsp_valid = rsp_en && (dq.size() > 0) && (!rs_rand || ($urandom_range(0, 1) == 1));
      rsp_data  = (dq.size() > 0) ? DW'(dq[0]) : '0;
    end
    #1;
    cv_e = active && (issued <= m_len) && (m_write || (m_out < MO));
    chk("req_ready", req_ready, !active);
    chk("busy", busy, active);
    chk("cmd_valid", cmd_valid, cv_e);
    chk("rsp_ready", rsp_ready, rd_ready || (m_out == 0));
    chk("rd_valid", rd_valid, rsp_valid && (m_out != 0));
    chk("rd_last", rd_last, active && !m_write && (issued > m_len) && (m_out == 1));
    chk("done", done, done_e);
    chk("err_unexp", err_unexp, eu_e);
    chk("err_mismatch", err_mismatch, em_e);
    if (rd_valid) chk("rd_data", rd_data, rsp_data);
    if (cv_e) begin
      chk("cmd_write", cmd_write, m_write);
      chk("cmd_addr", cmd_addr, (m_addr + issued) & AMASK);
      if (m_write) chk("cmd_data", cmd_data, (m_seed + issued) & DMASK);
    end
    if (cmd_valid && cmd_ready) obs_cmd_fires++;

    req_f  = rq && !active;
    done_e = 0;
    cfire  = cv_e && cmd_ready;
    rfire  = rsp_valid && (rd_ready || (m_out == 0));
    racc   = rfire && (m_out != 0);
    if (rfire && (m_out == 0)) eu_e = 1;
    if (rfire && !inj) void'(dq.pop_front());
    if (racc) begin
`ifdef HS_INIT_RD_CHECK_EN
      if (int'(rsp_data) != ((m_seed + resp_cnt) & DMASK)) em_e = 1;
`endif
      resp_cnt++;
      if (active && (issued > m_len) && (m_out == 1)) begin
        active = 0;
        done_e = 1;
      end
    end
    if (cfire) begin
      if (!m_write) dq.push_back((corrupt0 && issued == 0) ? ((m_seed + 1) & DMASK)
                                                             : ((m_seed + issued) & DMASK));
      if (m_write && issued == m_len) begin
        active = 0;
        done_e = 1;
      end
      issued++;
    end
    m_out = m_out + ((cfire && !m_write) ? 1 : 0) - (racc ? 1 : 0);
    if (req_f) begin
      active = 1; m_write = req_write; m_addr = int'(req_addr);
      m_len = int'(req_len); m_seed = int'(req_data); issued = 0; resp_cnt = 0;
    end
  endtask

  task automatic start(input bit w, input int a, input int l, input int s);
    req_write = w; req_addr = AW'(a); req_len = LW'(l); req_data = DW'(s);
    obs_cmd_fires = 0;
    cyc(1'b1);
  endtask

  task automatic finish(input int budget);
    int n = 0;
    while (active && n < budget) begin
      cyc(1'b0);
      n++;
    end
    cyc(1'b0);
    chk("idle_after_burst", busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rstn = 1'b0; req_valid = 0; req_write = 0; req_addr = '0; req_len = '0; req_data = '0;
    cmd_ready = 0; rsp_valid = 0; rsp_data = '0; rd_ready = 1;
    cr_rand = 0; rr_rand = 0; rs_rand = 0; rsp_en = 1; inj = 0; corrupt0 = 0;
    do_reset();
    cyc(1'b0);

    // Directed write: beats (E,5) (F,6) (0,7) (1,8), done 5 cycles after the request.
    start(1, 14, 3, 5);
    finish(20);
    chk("wr_beats", obs_cmd_fires, 4);

    // Read of 8 against a stalled responder: issue stops at 4 outstanding.
    rsp_en = 0;
    start(0, 3, 7, 9);
    repeat (10) cyc(1'b0);
    chk("stall_issue_cnt", obs_cmd_fires, 4);
    rsp_en = 1;
    finish(100);
    chk("rd_beats", obs_cmd_fires, 8);

    // Random writes with cmd_ready toggling.
    cr_rand = 1;
    for (int k = 0; k < 6; k++) begin
      start(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      finish(300);
    end

    // Random reads with random ready/valid on every channel.
    rr_rand = 1; rs_rand = 1;
    for (int k = 0; k < 6; k++) begin
      start(0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      finish(400);
    end
    cr_rand = 0; rr_rand = 0; rs_rand = 0;

    // Stray response in IDLE while downstream is not ready.
    rr_val = 0; inj = 1;
    cyc(1'b0);
    inj = 0; rr_val = 1;
    repeat (3) cyc(1'b0);

    // Reset in the middle of a read with two outstanding.
    rsp_en = 0;
    start(0, 0, 5, 2);
    cnt = 0;
    while (m_out < 2 && cnt < 20) begin
      cyc(1'b0);
      cnt++;
    end
    chk("two_outstanding", obs_cmd_fires, 2);
    do_reset();
    rsp_en = 1;
    start(0, 8, 2, 1);
    finish(50);

    // Corrupted first response.
    corrupt0 = 1;
    start(0, 4, 3, 6);
    finish(50);
    corrupt0 = 0;
    repeat (2) cyc(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hs_cmd_initiator.md
# hs_cmd_initiator

Command-issuing initiator for the valid/ready command-FIFO protocol (cmd bit 1 = write, 0 = read, plus addr and data, with in-order read data returned on a separate valid/ready channel). It converts one burst request into a sequence of single-beat commands with incrementing addresses and generated write data. It tracks outstanding reads and forwards read responses downstream. It sits upstream of the command FIFO / responder and is used both as a traffic generator and as a datapath front end.

## Interface
Parameters:
- DATA_WD, 4, data width of command and response beats
- ADDR_WD, 4, address width; addresses wrap modulo 2^ADDR_WD
- LEN_WD, 4, burst length field width; beats per burst = req_len + 1
- MAX_OUT, 4, maximum outstanding reads (>= 1); counter width clog2(MAX_OUT+1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous, active-low reset
- req_valid  in  1  burst request valid
- req_write  in  1  1: write burst, 0: read burst
- req_addr  in  ADDR_WD  start address
- req_len  in  LEN_WD  beats minus one
- req_data  in  DATA_WD  seed; beat i write data = seed + i (mod 2^DATA_WD)
- req_ready  out  1  request accepted when high with req_valid
- cmd_valid  out  1  command beat valid
- cmd_write  out  1  command type (1 write, 0 read)
- cmd_addr  out  ADDR_WD  command address
- cmd_data  out  DATA_WD  write data (value is don't-care on reads)
- cmd_ready  in  1  target accepts command
- rsp_valid  in  1  read data valid from target
- rsp_data  in  DATA_WD  read data
- rsp_ready  out  1  read data accepted
- rd_valid  out  1  read data to downstream
- rd_data  out  DATA_WD  equals rsp_data
- rd_last  out  1  marks the final response of the burst
- rd_ready  in  1  downstream accepts read data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on burst completion
- err_unexp  out  1  sticky; a response arrived with zero reads outstanding
- err_mismatch  out  1  sticky; read data did not match the expected pattern (see Configuration)

## Operation
- State machine states: IDLE, ISSUE, DRAIN.
- IDLE:
  - req_ready = 1.
  - On req fire, latch type, addr, len and seed; set the beat counter to 0; go to ISSUE.
- ISSUE:
  - cmd_valid = 1, except for a read when outstanding == MAX_OUT, in which case cmd_valid = 0.
  - On cmd fire, addr and beat counter each increment by 1, and cmd_data increments by 1. Addr wraps from 2^ADDR_WD-1 to 0.
  - On the last beat (counter == len) of a write burst, go to IDLE and pulse done.
  - On the last beat of a read burst, go to DRAIN.
- DRAIN: when a response fires with outstanding == 1, go to IDLE and pulse done.
- Outstanding counter:
  - +1 on read cmd fire; -1 on rsp fire.
  - If both happen in the same cycle, the counter is unchanged.
  - The counter never exceeds MAX_OUT.
- Response path:
  - rd_valid = rsp_valid && outstanding != 0.
  - rsp_ready = rd_ready || outstanding == 0.
  - When outstanding == 0, a response is consumed, dropped, and sets err_unexp.
- rd_last = (state == DRAIN) && outstanding == 1.
- cmd_valid stays high and cmd_* stay stable until cmd_ready; no beat is ever withdrawn.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1.
  - cmd_valid, cmd_write, cmd_addr, cmd_data, rd_valid, rd_last, busy, done, err_unexp, err_mismatch all = 0.
  - outstanding = 0.
- Reset mid-burst aborts the burst immediately: the state returns to IDLE, outstanding is cleared, and no done pulse is generated.
- Latency, with req fire at cycle T and cmd_ready held high:
  - The first cmd_valid is at T+1.
  - An N-beat burst issues at T+1..T+N, one beat per cycle.
  - Write: done at T+N+1, and req_ready is high again at T+N+1.
  - Read: done is one cycle after the last response fires.
- cmd_addr, cmd_data, cmd_write and done are registered. req_ready, cmd_valid, rsp_ready and rd_valid are combinational from state and counters.
- A new request is accepted only in IDLE; there is no overlap between bursts.

## Configuration
- HS_INIT_RD_CHECK_EN defined:
  - Each accepted read response i of the burst is compared against seed + i.
  - A mismatch sets err_mismatch, which is sticky until reset.
- HS_INIT_RD_CHECK_EN undefined: no compare logic is built and err_mismatch is tied 0.

## Test plan
- Write burst, addr=0xE, len=3, seed=5, cmd_ready=1 → cmd beats (addr, data) are (E,5), (F,6), (0,7), (1,8) on consecutive cycles; done at T+5.
- Read burst of 8 with MAX_OUT=4 and the responder stalled → cmd_valid drops after 4 issues; releasing the responder resumes issue; rd_last is on the 8th response; done follows.
- cmd_ready toggled randomly during a write → every beat is held stable until accepted; no beats are lost or duplicated.
- rsp_valid pulsed in IDLE with outstanding=0 → rsp_ready=1, rd_valid=0, err_unexp=1 and stays 1.
- rstn asserted mid read burst with 2 outstanding → all outputs return to reset values; a new burst then completes normally.
- With HS_INIT_RD_CHECK_EN, the responder returns seed+1 for beat 0 → err_mismatch=1; without the macro, err_mismatch stays 0.
